// File: rtl/qspi_rx_ctrl_if.sv
// Handshake and control bundle between the QSPI receive sequencer, the clock
// generator, the RX shift register and the word consumer.
interface qspi_rx_ctrl_if;
    logic       start_i;
    logic       lsb_first_i;
    logic [3:0] nibbles_i;
    logic [4:0] dummy_i;
    logic       cont_i;
    logic       abort_i;
    logic       sample_i;
    logic       word_ready_i;
    logic       sclk_en_o;
    logic       shift_valid_o;
    logic       shift_lsb_o;
    logic       shift_msb_o;
    logic       word_valid_o;
    logic       busy_o;
    logic       done_o;

    modport slave (
        input  start_i, lsb_first_i, nibbles_i, dummy_i, cont_i, abort_i,
               sample_i, word_ready_i,
        output sclk_en_o, shift_valid_o, shift_lsb_o, shift_msb_o,
               word_valid_o, busy_o, done_o
    );

    modport master (
        output start_i, lsb_first_i, nibbles_i, dummy_i, cont_i, abort_i,
               sample_i, word_ready_i,
        input  sclk_en_o, shift_valid_o, shift_lsb_o, shift_msb_o,
               word_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/qspi_rx_ctrl.sv
// QSPI receive sequencer: dummy phase, per-sample shift strobes for a 1..8
// nibble word, then a held word with valid/ready handshake and optional chaining.
module qspi_rx_ctrl (
    input  logic            clk_i,
    input  logic            rst_ni,
    qspi_rx_ctrl_if.slave   bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DUMMY = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [4:0] dcnt_q, dcnt_d;
    logic [2:0] ncnt_q, ncnt_d;
    logic       lsb_q, lsb_d;
    logic [3:0] nib_q, nib_d;
    logic [4:0] dummy_q, dummy_d;
    logic       wvld_q, wvld_d;
    logic       done_q, done_d;

    logic       strobe;
    logic       busy;
    logic [3:0] nib_norm;
    logic [4:0] dcnt_inc;
    logic [3:0] ncnt_inc;

    // Zero and anything above a full 32-bit word both mean "full word".
    assign nib_norm = ((bus.nibbles_i == 4'd0) || (bus.nibbles_i > 4'd8)) ? 4'd8
                                                                          : bus.nibbles_i;
    assign strobe   = (state_q == ST_SHIFT) && bus.sample_i && !bus.abort_i;
    assign busy     = (state_q != ST_IDLE);
    assign dcnt_inc = dcnt_q + 5'd1;
    assign ncnt_inc = {1'b0, ncnt_q} + 4'd1;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        ncnt_d  = ncnt_q;
        lsb_d   = lsb_q;
        nib_d   = nib_q;
        dummy_d = dummy_q;
        done_d  = 1'b0;
        if (bus.abort_i) begin
            state_d = ST_IDLE;
            dcnt_d  = 5'd0;
            ncnt_d  = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        lsb_d   = bus.lsb_first_i;
                        nib_d   = nib_norm;
                        dummy_d = bus.dummy_i;
                        dcnt_d  = 5'd0;
                        ncnt_d  = 3'd0;
                        state_d = (bus.dummy_i != 5'd0) ? ST_DUMMY : ST_SHIFT;
                    end
                end
                ST_DUMMY: begin
                    if (bus.sample_i) begin
                        if (dcnt_inc == dummy_q) begin
                            state_d = ST_SHIFT;
                            dcnt_d  = 5'd0;
                        end else begin
                            dcnt_d  = dcnt_inc;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (strobe) begin
                        if (ncnt_inc == nib_q) begin
                            state_d = ST_HOLD;
                            ncnt_d  = 3'd0;
                        end else begin
                            ncnt_d  = ncnt_inc[2:0];
                        end
                    end
                end
                default: begin
                    // Chained words reuse the latched configuration and skip dummies.
                    if (bus.word_ready_i) begin
                        if (bus.cont_i) begin
                            state_d = ST_SHIFT;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            endcase
        end
        wvld_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            dcnt_q  <= 5'd0;
            ncnt_q  <= 3'd0;
            lsb_q   <= 1'b0;
            nib_q   <= 4'd0;
            dummy_q <= 5'd0;
            wvld_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            ncnt_q  <= ncnt_d;
            lsb_q   <= lsb_d;
            nib_q   <= nib_d;
            dummy_q <= dummy_d;
            wvld_q  <= wvld_d;
            done_q  <= done_d;
        end
    end

    assign bus.sclk_en_o     = (state_q == ST_DUMMY) || (state_q == ST_SHIFT);
    assign bus.shift_valid_o = strobe;
    assign bus.shift_lsb_o   = busy && lsb_q;
    assign bus.shift_msb_o   = busy && !lsb_q;
    assign bus.word_valid_o  = wvld_q;
    assign bus.busy_o        = busy;
    assign bus.done_o        = done_q;
endmodule

// File: tb/tb_qspi_rx_ctrl.sv
// Bench for qspi_rx_ctrl: directed scenarios plus random traffic, every cycle
// compared against a countdown-style behavioural model of the sequencer.
module tb_qspi_rx_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    qspi_rx_ctrl_if bus();

    qspi_rx_ctrl dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    // Behavioural model: remaining dummy pulses / remaining nibbles.
    bit m_active, m_hold, m_lsb, m_done;
    int m_dummy_left, m_nib_left, m_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_outs();
        return {bus.sclk_en_o, bus.shift_valid_o, bus.shift_lsb_o, bus.shift_msb_o,
                bus.word_valid_o, bus.busy_o, bus.done_o};
    endfunction

    function automatic logic [6:0] model_outs();
        logic sclk, sv;
        sclk = m_active && !m_hold;
        sv   = sclk && (m_dummy_left == 0) && bus.sample_i && !bus.abort_i;
        return {sclk, sv, m_active && m_lsb, m_active && !m_lsb, m_hold, m_active, m_done};
    endfunction

    task automatic model_reset();
        m_active = 0; m_hold = 0; m_lsb = 0; m_done = 0;
        m_dummy_left = 0; m_nib_left = 0; m_n = 0;
    endtask

    task automatic model_tick();
        m_done = 0;
        if (bus.abort_i) begin
            m_active = 0; m_hold = 0; m_dummy_left = 0; m_nib_left = 0;
        end else if (!m_active) begin
            if (bus.start_i) begin
                m_active     = 1;
                m_lsb        = bus.lsb_first_i;
                m_n          = (bus.nibbles_i == 0 || bus.nibbles_i > 8) ? 8 : int'(bus.nibbles_i);
                m_nib_left   = m_n;
                m_dummy_left = int'(bus.dummy_i);
            end
        end else if (m_hold) begin
            if (bus.word_ready_i) begin
                m_hold = 0;
                if (bus.cont_i) m_nib_left = m_n;
                else begin m_active = 0; m_done = 1; end
            end
        end else if (bus.sample_i) begin
            if (m_dummy_left > 0) m_dummy_left--;
            else begin
                m_nib_left--;
                if (m_nib_left == 0) m_hold = 1;
            end
        end
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic step();
        #1;
        chk("outs", {25'd0, dut_outs()}, {25'd0, model_outs()});
        if (bus.shift_valid_o) strobes++;
        model_tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.start_i = 0; bus.lsb_first_i = 0; bus.nibbles_i = 0; bus.dummy_i = 0;
        bus.cont_i = 0; bus.abort_i = 0; bus.sample_i = 0; bus.word_ready_i = 0;
    endtask

    task automatic do_start(input bit l, input logic [3:0] n, input logic [4:0] d);
        bus.start_i = 1; bus.lsb_first_i = l; bus.nibbles_i = n; bus.dummy_i = d;
        step();
        bus.start_i = 0;
    endtask

    // Sample every cycle until the word is held; bounded.
    task automatic pulse_to_hold(input int max_cycles);
        int i;
        i = 0;
        bus.sample_i = 1;
        while (!m_hold && i < max_cycles) begin
            step();
            i++;
        end
        bus.sample_i = 0;
        if (!m_hold) chk("hold_timeout", 32'(i), 32'(max_cycles + 1));
    endtask

    task automatic handshake(input bit c);
        bus.word_ready_i = 1; bus.cont_i = c;
        step();
        bus.word_ready_i = 0; bus.cont_i = 0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        #12;
        chk("reset_outs", {25'd0, dut_outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        step();

        // Basic LSB word
        strobes = 0;
        do_start(1, 4'd8, 5'd0);
        pulse_to_hold(20);
        chk("basic_strobes", strobes, 8);
        chk("basic_wvalid", {31'd0, bus.word_valid_o}, 1);
        handshake(0);
        chk("basic_done", {31'd0, bus.done_o}, 1);
        chk("basic_busy", {31'd0, bus.busy_o}, 0);
        step();

        // Dummy cycles, MSB first, alternating sample pulses
        strobes = 0;
        do_start(0, 4'd2, 5'd4);
        for (int i = 0; i < 8; i++) begin
            bus.sample_i = 1; step();
            bus.sample_i = 0; step();
            if (i == 3) chk("dummy_nostrobe", strobes, 0);
        end
        chk("dummy_strobes", strobes, 2);
        chk("dummy_wvalid", {31'd0, bus.word_valid_o}, 1);
        handshake(0);
        step();

        // Nibble normalisation
        strobes = 0; do_start(1, 4'd0, 5'd0); pulse_to_hold(20);
        chk("nib0_strobes", strobes, 8); handshake(0);
        strobes = 0; do_start(0, 4'd12, 5'd0); pulse_to_hold(20);
        chk("nib12_strobes", strobes, 8); handshake(0);
        strobes = 0; do_start(1, 4'd1, 5'd0); pulse_to_hold(20);
        chk("nib1_strobes", strobes, 1); handshake(0);
        step();

        // Hold with delayed ready, then continuous mode
        strobes = 0;
        do_start(1, 4'd3, 5'd3);
        pulse_to_hold(20);
        chk("cont_first", strobes, 3);
        bus.sample_i = 1;
        for (int i = 0; i < 5; i++) step();
        chk("hold_nostrobe", strobes, 3);
        chk("hold_sclk", {31'd0, bus.sclk_en_o}, 0);
        handshake(1);
        bus.sample_i = 1; step(); bus.sample_i = 0;
        chk("cont_nodummy", strobes, 4);
        pulse_to_hold(20);
        chk("cont_second", strobes, 6);
        handshake(0);
        chk("cont_done", {31'd0, bus.done_o}, 1);
        step();

        // Abort after 3 strobes
        strobes = 0;
        do_start(1, 4'd8, 5'd0);
        bus.sample_i = 1;
        for (int i = 0; i < 3; i++) step();
        bus.abort_i = 1; step();
        bus.abort_i = 0; bus.sample_i = 0;
        chk("abort_strobes", strobes, 3);
        chk("abort_idle", {25'd0, dut_outs()}, 32'd0);
        step();
        strobes = 0; do_start(0, 4'd8, 5'd0); pulse_to_hold(20);
        chk("after_abort_strobes", strobes, 8);
        // Abort colliding with the handshake
        bus.word_ready_i = 1; bus.cont_i = 1; bus.abort_i = 1; step();
        clear_inputs();
        chk("abort_hs_done", {25'd0, dut_outs()}, 32'd0);
        step();

        // Start during SHIFT is ignored
        strobes = 0;
        do_start(1, 4'd4, 5'd0);
        bus.sample_i = 1; step(); step();
        bus.start_i = 1; bus.nibbles_i = 4'd1; bus.dummy_i = 5'd7; step();
        bus.start_i = 0;
        pulse_to_hold(20);
        chk("ign_start_strobes", strobes, 4);
        handshake(0);

        // Asynchronous reset mid-SHIFT
        do_start(0, 4'd8, 5'd2);
        bus.sample_i = 1; step(); step(); step();
        rst_n = 0;
        #1;
        chk("async_reset", {25'd0, dut_outs()}, 32'd0);
        model_reset();
        bus.sample_i = 0;
        #1 rst_n = 1;
        @(posedge clk); @(negedge clk);
        step();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            bus.start_i      = ($urandom_range(7) == 0);
            bus.lsb_first_i  = $urandom_range(1);
            bus.nibbles_i    = 4'($urandom_range(15));
            bus.dummy_i      = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(3));
            bus.cont_i       = $urandom_range(1);
            bus.abort_i      = ($urandom_range(79) == 0);
            bus.sample_i     = ($urandom_range(2) != 0);
            bus.word_ready_i = ($urandom_range(3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qspi_rx_ctrl.md
# qspi_rx_ctrl

Sequencer for the QSPI receive shift register. It waits out the programmed dummy cycles, then issues one shift strobe per SCLK sample edge until a word of 1–8 nibbles is captured. It holds the completed word with a valid/ready handshake, pausing SCLK meanwhile, and can chain words in continuous mode. It sits between the QSPI clock generator (sample strobes, SCLK enable) and the RX shift register (valid/lsb/msb controls).

## Interface
- No parameters. Word width is fixed at 32 bits (8 nibbles).
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous, active-low reset
- start_i  in  1  single-cycle request to begin a receive; accepted only in IDLE
- lsb_first_i  in  1  captured at start; 1 = shift in at the LSB end, 0 = at the MSB end
- nibbles_i  in  4  captured at start; nibbles per word; 0 or >8 is treated as 8
- dummy_i  in  5  captured at start; dummy sample edges before data (0–31)
- cont_i  in  1  sampled at the word handshake; 1 = receive another word
- abort_i  in  1  return to IDLE immediately
- sample_i  in  1  one-cycle pulse per SCLK sample edge, from the clock generator
- word_ready_i  in  1  consumer accepts the held word
- sclk_en_o  out  1  enables SCLK generation
- shift_valid_o  out  1  shift-register capture strobe
- shift_lsb_o  out  1  LSB-end shift select
- shift_msb_o  out  1  MSB-end shift select
- word_valid_o  out  1  a complete word is present on the shift-register output
- busy_o  out  1  high whenever not IDLE
- done_o  out  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, DUMMY, SHIFT, HOLD. Encoding is free.
- IDLE
  - start_i latches lsb_first_i, nibbles_i (normalised to 1..8) and dummy_i.
  - Next state is DUMMY if dummy_i≠0, else SHIFT.
  - A start_i outside IDLE is ignored.
- DUMMY
  - sclk_en_o=1. A 5-bit counter counts sample_i pulses.
  - On the pulse that makes the count equal dummy_i, go to SHIFT. No shift strobe is issued on that pulse.
- SHIFT
  - sclk_en_o=1.
  - shift_valid_o = sample_i, combinational, in the same cycle as the pulse.
  - A 3-bit nibble counter increments on each strobe.
  - On the strobe that completes nibble N, go to HOLD and clear the counter.
- HOLD
  - sclk_en_o=0 and word_valid_o=1. sample_i is ignored and no strobes are issued.
  - On word_ready_i with cont_i=1: go to SHIFT with the same configuration and no dummy phase.
  - On word_ready_i with cont_i=0: go to IDLE and pulse done_o for one cycle.
- Shift direction outputs
  - While busy, shift_lsb_o equals the latched lsb_first and shift_msb_o equals its inverse.
  - Both are 0 in IDLE.
  - They are exactly one-hot whenever shift_valid_o=1.
- abort_i
  - From any state, go to IDLE on the next edge and clear both counters.
  - No done_o pulse. shift_valid_o is forced to 0 in the abort cycle.
- Simultaneous events
  - abort_i has priority over start_i, sample_i and word_ready_i.
  - An abort_i coinciding with word_ready_i in HOLD is not a handshake: no done_o, and cont_i is ignored.
- Reset: every output is 0, state is IDLE, counters are 0 and latched configuration is 0.

## Timing
- start_i accepted at edge T: busy_o and sclk_en_o are high from T+1.
- shift_valid_o asserts in the same cycle as the qualifying sample_i, so the shift register captures at that cycle's edge.
- The edge that captures nibble N also moves the state to HOLD.
  - word_valid_o is registered and rises the cycle after that strobe, when the shift-register output already holds the full word.
  - sclk_en_o falls in that same cycle.
- word_valid_o stays high until the cycle after word_ready_i.
- done_o is high in the first IDLE cycle after the final handshake. busy_o is 0 in that cycle.
- Minimum latency from start to word_valid_o is dummy_i + N sample pulses plus 1 cycle.
- Back-to-back sample_i pulses (every cycle) must be supported with no lost strobes.

## Test plan
- Basic LSB word
  - Stimulus: reset; start with lsb_first=1, nibbles=8, dummy=0; 8 sample pulses.
  - Required: 8 shift_valid_o strobes with shift_lsb_o=1 and shift_msb_o=0; word_valid_o one cycle after the 8th strobe; word_ready_i → done_o pulse and busy_o=0.
- Dummy cycles
  - Stimulus: dummy=4, nibbles=2, lsb_first=0.
  - Required: first 4 sample pulses give no strobe; the next 2 strobe with shift_msb_o=1; word_valid_o follows.
- Nibble count normalisation
  - Stimulus: nibbles=0, then nibbles=12.
  - Required: both give 8 strobes. nibbles=1 gives exactly 1 strobe.
- Hold and continuous mode
  - Stimulus: during HOLD, keep sending sample_i and delay word_ready_i by 5 cycles; then handshake with cont_i=1.
  - Required: no strobes and sclk_en_o=0 during HOLD; after the handshake the next word starts without dummy cycles; final handshake with cont_i=0 gives done_o.
- Abort
  - Stimulus: abort_i after 3 strobes; separately, abort_i together with word_ready_i in HOLD.
  - Required: next cycle is IDLE with all outputs 0 and no done_o. A following start runs the full nibble count from zero.
- Reset and illegal start
  - Stimulus: assert rst_ni low mid-SHIFT; separately, pulse start_i during SHIFT.
  - Required: reset forces all outputs to 0 asynchronously. The mid-SHIFT start_i is ignored and the strobe count is unchanged.
